uart_tx_arbiter: RTL and testbench

Round-robin arbiter that shares the single UART transmit holding register (THR) among `NumReq` byte-stream requesters. It sits between the requesters (cores, debug bridge, log units) and the UART register file's THR write path. Each requester's message is kept atomic: the grant is held until the requester marks its last byte, or until the grant times out for inactivity. All writes are paced by the LSR THR-empty flag.

---
 rtl/uart_tx_arbiter.sv | 156 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART THR among NumReq byte-stream requesters.
// A grant stays locked until the owner's last byte or an inactivity timeout.
module uart_tx_arbiter #(
  parameter int NumReq      = 4,
  parameter int IdleTimeout = 256,
  parameter int IdxW        = $clog2(NumReq)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NumReq-1:0]     req_valid_i,
  input  logic [NumReq*8-1:0]   req_data_i,
  input  logic [NumReq-1:0]     req_last_i,
  output logic [NumReq-1:0]     req_ready_o,
  output logic [NumReq-1:0]     grant_o,
  output logic                  thr_write_o,
  output logic [7:0]            thr_data_o,
  input  logic                  thr_empty_i,
  output logic                  busy_o,
  output logic                  timeout_o,
  output logic [1:0]            dbg_state_o,
  output logic [IdxW-1:0]       dbg_rr_ptr_o
);

  // Handshake: a byte moves from requester i when req_valid_i[i] & req_ready_o[i]
  // are both high in the same cycle; only the granted requester ever sees ready.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StGrant = 2'd1,
    StWrite = 2'd2,
    StGuard = 2'd3
  } state_e;

  localparam int CntW = (IdleTimeout > 0) ? $clog2(IdleTimeout + 1) : 1;
  localparam logic [CntW-1:0] CntLast = (IdleTimeout > 0) ? CntW'(IdleTimeout - 1) : '0;
  localparam logic [CntW-1:0] CntMax  = '1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NumReq - 1);
  localparam logic [IdxW:0]   NumReqW = (IdxW + 1)'(NumReq);

  state_e            state_q, state_d;
  logic [IdxW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]   gnt_idx_q, gnt_idx_d;
  logic [CntW-1:0]   idle_cnt_q, idle_cnt_d;
  logic              last_q, last_d;
  logic [7:0]        thr_data_q, thr_data_d;
  logic              timeout_q, timeout_d;

  logic              pick_found;
  logic [IdxW-1:0]   pick_idx;
  logic [IdxW:0]     cand;
  logic [IdxW-1:0]   next_idx;
  logic              gnt_valid;
  logic              gnt_last;
  logic [7:0]        gnt_data;

  assign gnt_valid = req_valid_i[gnt_idx_q];
  assign gnt_last  = req_last_i[gnt_idx_q];
  assign gnt_data  = req_data_i[{gnt_idx_q, 3'b000} +: 8];
  assign next_idx  = (gnt_idx_q == IdxLast) ? '0 : gnt_idx_q + 1'b1;

  // Search starts at rr_ptr and wraps, so the first hit is the round-robin winner.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < NumReq; k++) begin
      cand = {1'b0, rr_ptr_q} + (IdxW + 1)'(k);
      if (cand >= NumReqW) cand = cand - NumReqW;
      if (!pick_found && req_valid_i[cand[IdxW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IdxW-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gnt_idx_d  = gnt_idx_q;
    idle_cnt_d = idle_cnt_q;
    last_d     = last_q;
    thr_data_d = thr_data_q;
    timeout_d  = 1'b0;
    case (state_q)
      StIdle: begin
        if (pick_found) begin
          gnt_idx_d  = pick_idx;
          idle_cnt_d = '0;
          state_d    = StGrant;
        end
      end
      StGrant: begin
        if (gnt_valid && thr_empty_i) begin
          thr_data_d = gnt_data;
          last_d     = gnt_last;
          idle_cnt_d = '0;
          state_d    = StWrite;
        end else if (!gnt_valid) begin
          // Only an absent owner ages the lock; back-pressure leaves the count alone.
          if (IdleTimeout != 0 && idle_cnt_q == CntLast) begin
            timeout_d = 1'b1;
            rr_ptr_d  = next_idx;
            state_d   = StIdle;
          end else if (idle_cnt_q != CntMax) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
          end
        end
      end
      StWrite: state_d = StGuard;
      StGuard: begin
        if (last_q) begin
          rr_ptr_d = next_idx;
          state_d  = StIdle;
        end else begin
          state_d = StGrant;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      gnt_idx_q  <= '0;
      idle_cnt_q <= '0;
      last_q     <= 1'b0;
      thr_data_q <= 8'h00;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gnt_idx_q  <= gnt_idx_d;
      idle_cnt_q <= idle_cnt_d;
      last_q     <= last_d;
      thr_data_q <= thr_data_d;
      timeout_q  <= timeout_d;
    end
  end

  // Ready follows thr_empty_i combinationally so an accept can land in the grant cycle.
  always_comb begin
    grant_o     = '0;
    req_ready_o = '0;
    if (state_q != StIdle) grant_o[gnt_idx_q] = 1'b1;
    if (state_q == StGrant) req_ready_o[gnt_idx_q] = thr_empty_i;
  end

  assign busy_o       = (state_q != StIdle);
  assign thr_write_o  = (state_q == StWrite);
  assign thr_data_o   = thr_data_q;
  assign timeout_o    = timeout_q;
  assign dbg_state_o  = state_q;
  assign dbg_rr_ptr_o = rr_ptr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic, checked against
// a cycle-level reference model and a strobe/timeout scoreboard.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;
  localparam int IW = 2;

  logic          clk;
  logic          rst_ni;
  logic [N-1:0]  req_valid;
  logic [N*8-1:0] req_data;
  logic [N-1:0]  req_last;
  logic [N-1:0]  req_ready_o;
  logic [N-1:0]  grant_o;
  logic          thr_write_o;
  logic [7:0]    thr_data_o;
  logic          thr_empty;
  logic          busy_o;
  logic          timeout_o;
  logic [1:0]    dbg_state_o;
  logic [IW-1:0] dbg_rr_ptr_o;

  uart_tx_arbiter #(.NumReq(N), .IdleTimeout(TO)) u_dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .req_valid_i  (req_valid),
    .req_data_i   (req_data),
    .req_last_i   (req_last),
    .req_ready_o  (req_ready_o),
    .grant_o      (grant_o),
    .thr_write_o  (thr_write_o),
    .thr_data_o   (thr_data_o),
    .thr_empty_i  (thr_empty),
    .busy_o       (busy_o),
    .timeout_o    (timeout_o),
    .dbg_state_o  (dbg_state_o),
    .dbg_rr_ptr_o (dbg_rr_ptr_o)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- scoreboard state ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [39:0] exp_q[$];   // {expected strobe cycle, data}
  logic [31:0] to_q[$];    // expected timeout pulse cycles

  // requester stimulus buffers
  logic [8:0] mbuf [N][512];
  int mhead [N];
  int mtail [N];
  int gap [N];
  logic [N-1:0] acc;
  bit rand_gaps;
  int empty_mode;   // 0: THR full, 1: THR empty, 2: random

  // reference model
  int m_owner, m_hold, m_idle, m_rr;
  bit m_last, m_sent;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_err++;
    $display("FAIL %s at cycle %0d", name, cyc);
  endtask

  task automatic model_reset();
    m_owner = -1; m_hold = 0; m_idle = 0; m_rr = 0; m_last = 0; m_sent = 0;
  endtask

  task automatic enq(input int r, input logic [7:0] d, input logic l);
    if (mhead[r] == mtail[r]) begin
      mhead[r] = 0;
      mtail[r] = 0;
    end
    mbuf[r][mtail[r]] = {l, d};
    mtail[r]++;
  endtask

  // Requesters hold valid/data until accepted; only after an accept may they pause.
  task automatic drive();
    for (int r = 0; r < N; r++) begin
      if (acc[r]) begin
        mhead[r]++;
        gap[r] = rand_gaps ? (($urandom_range(0, 9) == 0) ? 12 : int'($urandom_range(0, 2))) : 0;
      end
      if (req_valid[r] && !acc[r]) begin
        req_valid[r] = 1'b1;
      end else if (gap[r] > 0) begin
        req_valid[r] = 1'b0;
        gap[r]--;
      end else if (mhead[r] < mtail[r]) begin
        req_valid[r]          = 1'b1;
        req_data[r*8 +: 8]    = mbuf[r][mhead[r]][7:0];
        req_last[r]           = mbuf[r][mhead[r]][8];
      end else begin
        req_valid[r] = 1'b0;
      end
    end
    case (empty_mode)
      0:       thr_empty = 1'b0;
      1:       thr_empty = 1'b1;
      default: thr_empty = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  // Reference model: owner/hold/idle counters derived from the arbitration rules.
  task automatic model_step();
    logic [N-1:0] e_grant;
    logic [N-1:0] e_ready;
    logic [31:0]  ec;
    int nxt;
    e_grant = '0;
    e_ready = '0;
    if (m_owner >= 0) begin
      e_grant[m_owner] = 1'b1;
      if (m_hold == 0) e_ready[m_owner] = thr_empty;
    end
    check("grant", grant_o, e_grant);
    check("ready", req_ready_o, e_ready);
    check("busy", busy_o, (m_owner >= 0));
    check("rr_ptr", dbg_rr_ptr_o, m_rr[IW-1:0]);
    ec = cyc + 1;
    if (m_owner < 0) begin
      nxt = -1;
      for (int k = 0; k < N; k++) begin
        if (nxt < 0 && req_valid[(m_rr + k) % N]) nxt = (m_rr + k) % N;
      end
      if (nxt >= 0) begin
        m_owner = nxt; m_idle = 0; m_sent = 0;
      end
    end else if (m_hold > 0) begin
      m_hold--;
      if (m_hold == 0 && m_last) begin
        m_rr = (m_owner + 1) % N;
        m_owner = -1;
      end
    end else if (req_valid[m_owner] && thr_empty) begin
      exp_q.push_back({ec, req_data[m_owner*8 +: 8]});
      m_hold = 2; m_last = req_last[m_owner]; m_idle = 0; m_sent = 1;
    end else if (!req_valid[m_owner]) begin
      if (m_idle == TO - 1) begin
        to_q.push_back(ec);
        m_rr = (m_owner + 1) % N;
        m_owner = -1;
      end else begin
        m_idle++;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    model_step();
    acc = req_valid & req_ready_o;
    @(posedge clk);
    #1;
    drive();
  endtask

  function automatic bit all_quiet();
    bit q;
    q = (m_owner < 0) && (req_valid == '0) && (exp_q.size() == 0) && (to_q.size() == 0);
    for (int r = 0; r < N; r++) if (mhead[r] < mtail[r]) q = 0;
    return q;
  endfunction

  task automatic run_drain(input string name, input int budget);
    int k;
    k = 0;
    while (!all_quiet() && k < budget) begin
      step();
      k++;
    end
    if (k >= budget) fail_now({name, "_drain_timeout"});
    repeat (4) step();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_grant"}, grant_o, 0);
    check({tag, "_ready"}, req_ready_o, 0);
    check({tag, "_write"}, thr_write_o, 0);
    check({tag, "_data"}, thr_data_o, 0);
    check({tag, "_busy"}, busy_o, 0);
    check({tag, "_timeout"}, timeout_o, 0);
    check({tag, "_rr"}, dbg_rr_ptr_o, 0);
    check({tag, "_state"}, dbg_state_o, 0);
  endtask

  task automatic clear_stim();
    for (int r = 0; r < N; r++) begin
      mhead[r] = 0; mtail[r] = 0; gap[r] = 0;
    end
    req_valid = '0; req_data = '0; req_last = '0; acc = '0;
  endtask

  // ---------------- monitor ----------------
  initial forever begin
    logic [39:0] e;
    logic [31:0] t;
    @(negedge clk);
    if (rst_ni) begin
      while (exp_q.size() > 0 && exp_q[0][39:8] < cyc) begin
        e = exp_q.pop_front();
        fail_now("missed_strobe");
      end
      while (to_q.size() > 0 && to_q[0] < cyc) begin
        t = to_q.pop_front();
        fail_now("missed_timeout");
      end
      if (thr_write_o) begin
        if (exp_q.size() == 0) fail_now("unexpected_strobe");
        else begin
          e = exp_q.pop_front();
          check("strobe_cycle", cyc, e[39:8]);
          check("strobe_data", thr_data_o, e[7:0]);
        end
      end
      if (timeout_o) begin
        if (to_q.size() == 0) fail_now("unexpected_timeout");
        else begin
          t = to_q.pop_front();
          check("timeout_cycle", cyc, t);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int k;
    rst_ni = 1'b0;
    thr_empty = 1'b1;
    rand_gaps = 0;
    empty_mode = 1;
    clear_stim();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst_ni = 1'b1;
    drive();

    // fairness: single-byte messages from everyone, req 0 twice
    for (int r = 0; r < N; r++) enq(r, 8'hA0 + 8'(r), 1'b1);
    enq(0, 8'hB0, 1'b1);
    run_drain("fair", 200);
    check("rr_after_fair", dbg_rr_ptr_o, 1);

    // single requester, two-byte message
    enq(2, 8'h41, 1'b0);
    enq(2, 8'h42, 1'b1);
    run_drain("single", 100);
    check("rr_after_single", dbg_rr_ptr_o, 3);

    // atomicity: req 0 three bytes while req 1 waits
    enq(0, 8'h01, 1'b0); enq(0, 8'h02, 1'b0); enq(0, 8'h03, 1'b1);
    enq(1, 8'h11, 1'b1);
    run_drain("atomic", 200);

    // back-pressure for 500 cycles
    empty_mode = 0;
    enq(1, 8'h55, 1'b1);
    repeat (500) step();
    empty_mode = 1;
    run_drain("backpressure", 100);

    // timeout: req 3 sends a non-last byte then goes silent; req 0 waits
    enq(3, 8'h10, 1'b0);
    k = 0;
    while (m_owner != 3 && k < 50) begin step(); k++; end
    if (k >= 50) fail_now("timeout_no_grant");
    enq(0, 8'h77, 1'b1);
    run_drain("timeout", 200);

    // random traffic
    rand_gaps = 1;
    empty_mode = 2;
    for (int m = 0; m < 40; m++) begin
      int r, len;
      r = $urandom_range(0, N - 1);
      len = $urandom_range(1, 4);
      for (int b = 0; b < len; b++) enq(r, 8'($urandom_range(0, 255)), (b == len - 1));
    end
    run_drain("random", 20000);

    // reset in the middle of a message
    rand_gaps = 0;
    empty_mode = 1;
    enq(1, 8'hC1, 1'b0); enq(1, 8'hC2, 1'b0); enq(1, 8'hC3, 1'b1);
    k = 0;
    while (!(m_owner == 1 && m_hold == 0 && m_sent) && k < 50) begin step(); k++; end
    if (k >= 50) fail_now("midreset_setup");
    #1 thr_empty = 1'b0;
    #1 rst_ni = 1'b0;
    #1;
    check_reset_outputs("midreset");
    clear_stim();
    model_reset();
    exp_q.delete();
    to_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b1;
    enq(3, 8'h33, 1'b1);
    enq(1, 8'h11, 1'b1);
    drive();
    run_drain("after_reset", 200);

    check("final_exp_q_empty", exp_q.size(), 0);
    check("final_to_q_empty", to_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule
